// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: timer register map, control/status
// bit positions, FSM state encoding and small helpers.
package timer_sched_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h08;
  localparam logic [7:0] ADDR_STATUS    = 8'h09;
  localparam logic [7:0] ADDR_PRESCALER = 8'h0a;
  localparam logic [7:0] ADDR_TIMER     = 8'h0b;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_STOP_BIT    = 1;
  localparam int STATUS_READY_BIT = 0;

  // Requester index width; NUM_REQ never exceeds 4.
  localparam int PTR_W = 2;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    STOP0,
    WR_PRESC,
    WR_TIMER,
    WR_START,
    SETTLE,
    POLL_WAIT,
    POLL,
    DONE,
    CANCEL
  } state_t;

  function automatic logic [31:0] ctrl_word(input int bit_pos);
    return 32'd1 << bit_pos;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [3:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = PTR_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/timer_sched_arb.sv
// Combinational requester picker: round-robin starting at rr_ptr, or fixed
// priority (lowest index wins) when TIMER_SCHED_FIXED_PRIO_EN is defined.
module timer_sched_arb
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
`ifndef TIMER_SCHED_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   rr_ptr,
`endif
  output logic [NUM_REQ-1:0] grant
);

`ifdef TIMER_SCHED_FIXED_PRIO_EN
  assign grant = req_valid & (~req_valid + NUM_REQ'(1));
`else
  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      hi_mask[i] = (i >= int'(rr_ptr));
  end

  assign hi_req = req_valid & hi_mask;

  // x & -x isolates the lowest set bit; with nothing at/after rr_ptr the search wraps to bit 0.
  assign grant = (hi_req != '0) ? (hi_req & (~hi_req + NUM_REQ'(1)))
                                : (req_valid & (~req_valid + NUM_REQ'(1)));
`endif

endmodule

// File: rtl/timer_sched.sv
// Shares one timer peripheral between NUM_REQ requesters by driving its register bus.
// Build option: TIMER_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int          NUM_REQ   = 2,
  parameter logic [31:0] PRESCALER = 32'd18000,
  parameter int          POLL_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_timeout,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  busy,
  output logic                  tmr_cs,
  output logic                  tmr_we,
  output logic [7:0]            tmr_address,
  output logic [31:0]           tmr_write_data,
  input  logic [31:0]           tmr_read_data,
  input  logic                  tmr_ready
);

  localparam logic [7:0] SETTLE_LAST = 8'd1;
  localparam logic [7:0] GAP_LAST    = 8'(POLL_GAP - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q;
  logic [31:0]        timeout_q;
  logic [31:0]        sel_timeout;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant_d;
  logic [NUM_REQ-1:0] done_d;
  logic               cs_d, we_d;
  logic [7:0]         addr_d;
  logic [31:0]        wdata_d;
  logic               acc_done;
  logic               cancel;
  logic               status_idle;
  logic               unused_rd;

  assign acc_done    = tmr_cs && tmr_ready;
  assign cancel      = (req_valid & req_grant) == '0;
  assign status_idle = tmr_read_data[STATUS_READY_BIT];
  assign unused_rd   = ^tmr_read_data;

`ifdef TIMER_SCHED_FIXED_PRIO_EN
  timer_sched_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .grant     (arb_grant)
  );
`else
  logic [PTR_W-1:0] rr_q;
  logic [PTR_W-1:0] owner_idx;

  assign owner_idx = onehot_idx(4'(req_grant));

  timer_sched_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_q),
    .grant     (arb_grant)
  );

  // The pointer moves past the finishing owner so a waiting peer wins next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_q <= '0;
    else if (state_q == DONE || (state_q == CANCEL && acc_done))
      rr_q <= (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
  end
`endif

  always_comb begin
    sel_timeout = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_grant[i]) sel_timeout |= req_timeout[32*i +: 32];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_valid != '0) state_d = CHECK;
      CHECK: begin
        if (acc_done) begin
          if (cancel)                state_d = CANCEL;
          else if (!status_idle)     state_d = STOP0;
          else if (timeout_q == '0)  state_d = DONE;
          else                       state_d = WR_PRESC;
        end
      end
      STOP0:     if (acc_done) state_d = cancel ? CANCEL : CHECK;
      WR_PRESC:  if (acc_done) state_d = cancel ? CANCEL : WR_TIMER;
      WR_TIMER:  if (acc_done) state_d = cancel ? CANCEL : WR_START;
      WR_START:  if (acc_done) state_d = cancel ? CANCEL : SETTLE;
      SETTLE: begin
        if (cancel)                   state_d = CANCEL;
        else if (cnt_q == SETTLE_LAST) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (cancel)                state_d = CANCEL;
        else if (cnt_q == GAP_LAST) state_d = POLL;
      end
      POLL: begin
        if (acc_done) begin
          if (cancel)           state_d = CANCEL;
          else if (status_idle) state_d = DONE;
          else                  state_d = POLL_WAIT;
        end
      end
      DONE:      state_d = IDLE;
      CANCEL:    if (acc_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so each access
  // holds steady for as long as its state lasts.
  always_comb begin
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      CHECK, POLL: begin
        cs_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      STOP0, CANCEL: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_word(CTRL_STOP_BIT);
      end
      WR_PRESC: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_PRESCALER;
        wdata_d = PRESCALER;
      end
      WR_TIMER: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_TIMER;
        wdata_d = timeout_q;
      end
      WR_START: begin
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_word(CTRL_START_BIT);
      end
      default: ;
    endcase
  end

  always_comb begin
    grant_d = req_grant;
    if (state_q == IDLE && state_d == CHECK)
      grant_d = arb_grant;
    else if (state_d == IDLE)
      grant_d = '0;
    done_d = (state_d == DONE) ? req_grant : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_grant      <= '0;
      req_done       <= '0;
      busy           <= 1'b0;
      tmr_cs         <= 1'b0;
      tmr_we         <= 1'b0;
      tmr_address    <= '0;
      tmr_write_data <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
      req_grant      <= grant_d;
      req_done       <= done_d;
      busy           <= (state_d != IDLE);
      tmr_cs         <= cs_d;
      tmr_we         <= we_d;
      tmr_address    <= addr_d;
      tmr_write_data <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE)
      timeout_q <= sel_timeout;
  end

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural timer peripheral on the bus.
module tb_timer_sched;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [63:0] req_timeout;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic        busy;
  logic        tmr_cs;
  logic        tmr_we;
  logic [7:0]  tmr_address;
  logic [31:0] tmr_write_data;
  logic [31:0] tmr_read_data;
  logic        tmr_ready;

  timer_sched #(.NUM_REQ(2), .PRESCALER(32'd4), .POLL_GAP(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_timeout    (req_timeout),
    .req_grant      (req_grant),
    .req_done       (req_done),
    .busy           (busy),
    .tmr_cs         (tmr_cs),
    .tmr_we         (tmr_we),
    .tmr_address    (tmr_address),
    .tmr_write_data (tmr_write_data),
    .tmr_read_data  (tmr_read_data),
    .tmr_ready      (tmr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timer peripheral: one wait state per access, counts timer*prescaler cycles after start.
  logic        kick;
  logic        m_run, m_rdy;
  logic [31:0] m_presc, m_timer, m_rem;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run   <= 1'b0;
      m_rdy   <= 1'b0;
      m_presc <= '0;
      m_timer <= '0;
      m_rem   <= '0;
    end else begin
      m_rdy <= tmr_cs && !m_rdy;
      if (kick) begin
        m_run <= 1'b1;
        m_rem <= 32'd100000;
      end else if (tmr_cs && m_rdy && tmr_we) begin
        if (tmr_address == 8'h0a) m_presc <= tmr_write_data;
        else if (tmr_address == 8'h0b) m_timer <= tmr_write_data;
        else if (tmr_address == 8'h08) begin
          if (tmr_write_data[0]) begin
            m_run <= 1'b1;
            m_rem <= m_timer * m_presc;
          end else if (tmr_write_data[1]) m_run <= 1'b0;
        end
      end else if (m_run) begin
        m_rem <= m_rem - 32'd1;
        if (m_rem <= 32'd1) m_run <= 1'b0;
      end
    end
  end

  assign tmr_ready     = m_rdy;
  assign tmr_read_data = (tmr_address == 8'h09) ? {31'd0, ~m_run} : 32'd0;

  // Bus / handshake monitor
  logic [39:0] wr_q[$];
  logic [1:0]  done_q[$];
  logic [1:0]  gnt_q[$];
  int          n_rd = 0;
  int          overlap_cnt = 0;
  logic [1:0]  prev_grant = 2'b00;

  always @(posedge clk) begin
    if (reset_n) begin
      if (tmr_cs && tmr_ready) begin
        if (tmr_we) wr_q.push_back({tmr_address, tmr_write_data});
        else if (tmr_address == 8'h09) n_rd++;
      end
      if (req_done != 2'b00) done_q.push_back(req_done);
      if (req_done != 2'b00 && req_grant != 2'b00 && req_grant != req_done) overlap_cnt++;
      if (req_grant != 2'b00 && prev_grant == 2'b00) gnt_q.push_back(req_grant);
    end
    prev_grant = req_grant;
  end

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] tmo;
    logic [1:0]  grant;
    int          nwr;
  } vec_t;

  vec_t vecs[5];

  task automatic run_one(input int idx, input logic [31:0] tmo, input logic [1:0] exp_oh,
                         input int exp_nwr, input string tag);
    int wbase, rbase, c;
    wbase = wr_q.size();
    rbase = n_rd;
    req_timeout[32*idx +: 32] = tmo;
    req_valid[idx] = 1'b1;
    c = 0;
    while (req_grant == 2'b00 && c < 50) begin @(negedge clk); c++; end
    chk({tag, " grant"}, req_grant, exp_oh);
    c = 0;
    while (req_done == 2'b00 && c < 2000) begin @(negedge clk); c++; end
    chk({tag, " done"}, req_done, exp_oh);
    chk({tag, " busy at done"}, busy, 1'b1);
    if (exp_nwr == 0) begin
      chk({tag, " zero latency"}, (c <= 3), 1'b1);
      chk({tag, " status reads"}, n_rd - rbase, 1);
    end
    req_valid[idx] = 1'b0;
    @(negedge clk);
    chk({tag, " busy after"}, busy, 1'b0);
    chk({tag, " done width"}, req_done, 2'b00);
    chk({tag, " grant cleared"}, req_grant, 2'b00);
    chk({tag, " write count"}, wr_q.size() - wbase, exp_nwr);
    if (exp_nwr == 3 && wr_q.size() >= wbase + 3) begin
      chk({tag, " presc write"}, wr_q[wbase],   {8'h0a, 32'd4});
      chk({tag, " timer write"}, wr_q[wbase+1], {8'h0b, tmo});
      chk({tag, " start write"}, wr_q[wbase+2], {8'h08, 32'd1});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, wbase, dbase, gbase, rbase;
    logic [1:0] exp_seq[3];

    reset_n     = 1'b0;
    req_valid   = 2'b00;
    req_timeout = '0;
    kick        = 1'b0;

    vecs[0] = '{idx: 0, tmo: 32'd5, grant: 2'b01, nwr: 3};
    vecs[1] = '{idx: 1, tmo: 32'd3, grant: 2'b10, nwr: 3};
    vecs[2] = '{idx: 0, tmo: 32'd0, grant: 2'b01, nwr: 0};
    vecs[3] = '{idx: 1, tmo: 32'd0, grant: 2'b10, nwr: 0};
    vecs[4] = '{idx: 1, tmo: 32'd2, grant: 2'b10, nwr: 3};

`ifdef TIMER_SCHED_FIXED_PRIO_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`endif

    repeat (3) @(negedge clk);
    chk("reset grant", req_grant, 2'b00);
    chk("reset done", req_done, 2'b00);
    chk("reset busy", busy, 1'b0);
    chk("reset cs", tmr_cs, 1'b0);
    chk("reset we", tmr_we, 1'b0);
    chk("reset addr", tmr_address, 8'h00);
    chk("reset wdata", tmr_write_data, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_one(vecs[v].idx, vecs[v].tmo, vecs[v].grant, vecs[v].nwr, $sformatf("vec%0d", v));

    // Contention: requester 0 keeps asking after its first completion.
    gbase = gnt_q.size();
    req_timeout = {32'd7, 32'd3};
    req_valid   = 2'b11;
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (req_done == 2'b00 && c < 1000) begin @(negedge clk); c++; end
      chk($sformatf("arb done%0d", k), req_done, exp_seq[k]);
      if (k > 0) req_valid = req_valid & ~req_done;
      @(negedge clk);
    end
    chk("arb grant count", gnt_q.size() - gbase, 3);
    if (gnt_q.size() >= gbase + 3)
      for (int k = 0; k < 3; k++)
        chk($sformatf("arb grant%0d", k), gnt_q[gbase+k], exp_seq[k]);

    // Timer found running at CHECK.
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    wbase = wr_q.size();
    rbase = n_rd;
    req_timeout[31:0] = 32'd2;
    req_valid = 2'b01;
    c = 0;
    while (req_done == 2'b00 && c < 1000) begin @(negedge clk); c++; end
    chk("running done", req_done, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    chk("running write count", wr_q.size() - wbase, 4);
    if (wr_q.size() >= wbase + 4) begin
      chk("running stop", wr_q[wbase],   {8'h08, 32'd2});
      chk("running presc", wr_q[wbase+1], {8'h0a, 32'd4});
      chk("running timer", wr_q[wbase+2], {8'h0b, 32'd2});
      chk("running start", wr_q[wbase+3], {8'h08, 32'd1});
    end
    chk("running status reads", (n_rd - rbase) >= 3, 1'b1);

    // Cancel during POLL_WAIT, peer served afterwards.
    wbase = wr_q.size();
    dbase = done_q.size();
    gbase = gnt_q.size();
    req_timeout = {32'd2, 32'd1000};
    req_valid   = 2'b01;
    c = 0;
    while (wr_q.size() < wbase + 3 && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    chk("cancel bus idle in gap", tmr_cs, 1'b0);
    req_valid = 2'b10;
    c = 0;
    while (req_done == 2'b00 && c < 1000) begin @(negedge clk); c++; end
    chk("cancel peer done", req_done, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);
    chk("cancel write present", wr_q.size() >= wbase + 4, 1'b1);
    if (wr_q.size() >= wbase + 4)
      chk("cancel stop write", wr_q[wbase+3], {8'h08, 32'd2});
    chk("cancel done pulses", done_q.size() - dbase, 1);
    chk("cancel grant count", gnt_q.size() - gbase, 2);
    if (gnt_q.size() >= gbase + 2)
      chk("cancel next grant", gnt_q[gbase+1], 2'b10);

    // Asynchronous reset while a status poll is on the bus.
    wbase = wr_q.size();
    req_timeout = {32'd1000, 32'd0};
    req_valid   = 2'b10;
    c = 0;
    while (wr_q.size() < wbase + 3 && c < 200) begin @(negedge clk); c++; end
    repeat (6) @(negedge clk);
    chk("pre-reset poll cs", tmr_cs, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async grant", req_grant, 2'b00);
    chk("async done", req_done, 2'b00);
    chk("async busy", busy, 1'b0);
    chk("async cs", tmr_cs, 1'b0);
    chk("async we", tmr_we, 1'b0);
    chk("async addr", tmr_address, 8'h00);
    chk("async wdata", tmr_write_data, 32'h0);
    req_timeout = {32'd2, 32'd1};
    req_valid   = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    c = 0;
    while (req_grant == 2'b00 && c < 50) begin @(negedge clk); c++; end
    chk("post-reset first grant", req_grant, 2'b01);
    c = 0;
    while (req_done == 2'b00 && c < 1000) begin @(negedge clk); c++; end
    chk("post-reset done0", req_done, 2'b01);
    req_valid = 2'b10;
    @(negedge clk);
    c = 0;
    while (req_done == 2'b00 && c < 1000) begin @(negedge clk); c++; end
    chk("post-reset done1", req_done, 2'b10);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);

    chk("grant/done overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
